// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: instruction kinds and FSM states.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    KIND_PUSH = 2'b00,
    KIND_POP  = 2'b01,
    KIND_ALU  = 2'b10,
    KIND_CLRF = 2'b11
  } ins_kind_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_WB   = 2'b10
  } seq_state_e;

endpackage

// File: rtl/alu_seq_stack.sv
// Operand stack: register array with push, pop and replace-two-with-one,
// exposing the top and second-from-top entries combinationally.
module alu_seq_stack
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             replace2,
  input  logic [WIDTH-1:0] push_data,
  input  logic [WIDTH-1:0] replace_data,
  output logic [CW-1:0]    depth,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    idx_top;
  logic [AW-1:0]    idx_sec;
  logic [AW-1:0]    idx_push;

  assign idx_top  = AW'(depth - CW'(1));
  assign idx_sec  = AW'(depth - CW'(2));
  assign idx_push = AW'(depth);

  // Contents are deliberately not reset; only the pointer is.
  always_ff @(posedge clk) begin
    if (push)
      mem[idx_push] <= push_data;
    else if (replace2)
      mem[idx_sec] <= replace_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      depth <= '0;
    else if (push)
      depth <= depth + CW'(1);
    else if (pop || replace2)
      depth <= depth - CW'(1);
  end

  assign top    = (depth != '0)      ? mem[idx_top] : '0;
  assign second = (depth > CW'(1))   ? mem[idx_sec] : '0;

endmodule

// File: rtl/alu_sequencer.sv
// Stack-machine sequencer feeding an external combinational ALU (IDLE/EXEC/WB).
// Optional macro ALU_SEQ_CARRY_CHAIN_EN: issue the carry flag as ALU carry-in.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ins_valid,
  output logic             ins_ready,
  input  logic [1:0]       ins_kind,
  input  logic [3:0]       ins_opcode,
  input  logic [WIDTH-1:0] ins_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_ic,
  output logic [3:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_oc,
  input  logic             alu_oo,
  output logic [WIDTH-1:0] tos,
  output logic [CW-1:0]    depth,
  output logic             carry,
  output logic             overflow,
  output logic             err
);

  seq_state_e       state, state_next;
  logic             push, pop, replace2, issue, clrf, err_set;
  logic [WIDTH-1:0] second;

  alu_seq_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .replace2     (replace2),
    .push_data    (ins_imm),
    .replace_data (alu_out),
    .depth        (depth),
    .top          (tos),
    .second       (second)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    pop        = 1'b0;
    replace2   = 1'b0;
    issue      = 1'b0;
    clrf       = 1'b0;
    err_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (ins_valid) begin
          case (ins_kind_e'(ins_kind))
            KIND_PUSH: if (depth == CW'(DEPTH)) err_set = 1'b1; else push = 1'b1;
            KIND_POP:  if (depth == '0)         err_set = 1'b1; else pop  = 1'b1;
            KIND_ALU: begin
              if (depth < CW'(2)) begin
                err_set = 1'b1;
              end else begin
                issue      = 1'b1;
                state_next = S_EXEC;
              end
            end
            KIND_CLRF: clrf = 1'b1;
            default:   ;
          endcase
        end
      end
      S_EXEC: state_next = S_WB;
      S_WB: begin
        replace2   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign ins_ready = (state == S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry    <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= err_set;
      if (clrf) begin
        carry    <= 1'b0;
        overflow <= 1'b0;
      end else if (replace2) begin
        carry    <= alu_oc;
        overflow <= alu_oo;
      end
    end
  end

  // Operands stay at their last issued values until the next ALU issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
    end else if (issue) begin
      alu_a      <= second;
      alu_b      <= tos;
      alu_opcode <= ins_opcode;
    end
  end

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      alu_ic <= 1'b0;
    else if (issue)
      alu_ic <= carry;
  end
`else
  assign alu_ic = 1'b0;
`endif

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (matches alu WIDTH).
REQ-002 SHALL have parameter DEPTH, default 8, operand stack entries (power of 2, >=2).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port ins_valid  input  1  instruction offered.
REQ-006 SHALL have port ins_ready  output  1  instruction accepted when ins_valid&&ins_ready.
REQ-007 SHALL have port ins_kind  input  2  00 PUSH, 01 POP, 10 ALU, 11 CLRF.
REQ-008 SHALL have port ins_opcode  input  4  ALU opcode, used when ins_kind=ALU.
REQ-009 SHALL have port ins_imm  input  WIDTH  PUSH value.
REQ-010 SHALL have ports alu_a, alu_b  output  WIDTH each  registered ALU operands (a=second, b=top of stack).
REQ-011 SHALL have ports alu_ic  output  1 and alu_opcode  output  4  registered carry-in and opcode.
REQ-012 SHALL have ports alu_out  input  WIDTH, alu_oc  input  1, alu_oo  input  1  combinational ALU results.
REQ-013 SHALL have ports tos  output  WIDTH, depth  output  $clog2(DEPTH+1), carry  output  1, overflow  output  1, err  output  1.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, WB; ins_ready=1 only in IDLE.
REQ-015 PUSH in IDLE: write ins_imm at top, depth+1, tos=ins_imm next cycle; stay IDLE (1-cycle).
REQ-016 POP in IDLE: depth-1, tos=new top next cycle; stay IDLE.
REQ-017 CLRF in IDLE: carry=0, overflow=0 next cycle; stay IDLE.
REQ-018 ALU in IDLE with depth>=2: register alu_a=stack[depth-2], alu_b=stack[depth-1], alu_opcode=ins_opcode, alu_ic per REQ-029; go EXEC.
REQ-019 EXEC: alu_* held stable one full cycle; go WB.
REQ-020 WB: sample alu_out/alu_oc/alu_oo; replace two operands with alu_out (depth-1), carry=alu_oc, overflow=alu_oo; go IDLE; ins_ready high following cycle (accept-to-accept latency 3 cycles).
REQ-021 alu_* outputs SHALL hold last issued values outside EXEC/WB.
REQ-022 Errors: PUSH at depth=DEPTH, POP at depth=0, ALU at depth<2 SHALL be accepted, change no state, pulse err high exactly one cycle.
REQ-023 err SHALL be 0 in all other cycles; no sticky error.
REQ-024 tos SHALL equal stack[depth-1] when depth>0, else 0.
REQ-025 Stack pointer SHALL never wrap; depth bounded 0..DEPTH.
REQ-026 ins_* SHALL be ignored when ins_valid=0 or state!=IDLE.

Reset
REQ-027 Reset SHALL force IDLE, depth=0, tos=0, carry=0, overflow=0, err=0, alu_a=alu_b=0, alu_ic=0, alu_opcode=0, ins_ready=1 after deassert; stack contents need not clear.
REQ-028 Reset during EXEC/WB SHALL abandon the operation with no writeback.

Configuration
REQ-029 With ALU_SEQ_CARRY_CHAIN_EN defined, alu_ic SHALL be registered from carry flag at issue; without it, alu_ic SHALL be constant 0 and carry still updates from alu_oc.

Structure
REQ-030 Package alu_seq_pkg SHALL hold ins_kind enum (PUSH/POP/ALU/CLRF) and FSM state enum.
REQ-031 Stack storage SHALL be sub-module alu_seq_stack (register array, push/pop/replace2 ports, top and second read ports).

Verification
REQ-032 Reset, then PUSH 5, PUSH 7 -> depth=2, tos=7, err never high.
REQ-033 PUSH 0xFFFFFFFF, PUSH 1, ALU op 0 with bench model add returning out=0, oc=1, oo=0 -> alu_a=0xFFFFFFFF, alu_b=1 during EXEC, after WB tos=0, depth=1, carry=1, ins_ready low exactly 2 cycles.
REQ-034 With ALU_SEQ_CARRY_CHAIN_EN, carry=1 then PUSH 2, PUSH 3, ALU op 0 -> alu_ic=1; without macro alu_ic=0.
REQ-035 From reset, POP -> err one-cycle pulse, depth=0; ALU with depth=1 -> err pulse, tos unchanged.
REQ-036 PUSH 8 values (DEPTH=8), 9th PUSH 0xAA -> err pulse, depth=8, tos=8th value.
REQ-037 Assert reset during EXEC -> depth=0, carry=0, state IDLE, no writeback on release.
